// File: rtl/axi4_pkg.sv
// AXI4 protocol constants shared by every AXI master and slave in the data path.
package axi4;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

endpackage

// File: rtl/lsu_pkg.sv
// Load/store request and response bundles shared between the core memory stage and axi_lsu.
package lsu_pkg;

  localparam int LSU_ADDR_W = 32;
  localparam int LSU_DATA_W = 32;
  localparam int LSU_STRB_W = LSU_DATA_W / 8;

  typedef struct packed {
    logic                  write;
    logic [LSU_ADDR_W-1:0] addr;
    logic [LSU_DATA_W-1:0] wdata;
    logic [LSU_STRB_W-1:0] wstrb;
  } lsu_req_t;

  typedef struct packed {
    logic [LSU_DATA_W-1:0] rdata;
    logic                  err;
  } lsu_rsp_t;

  function automatic logic word_aligned(input logic [LSU_ADDR_W-1:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/axi_if.sv
// AXI4-Lite bundle (AW/W/B/AR/R) with master and slave views.
interface axi #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input logic aclk,
  input logic aresetn
);

  logic                    awvalid, awready;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    wvalid, wready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    bvalid, bready;
  axi4::resp_t             bresp;
  logic                    arvalid, arready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    rvalid, rready;
  logic [DATA_WIDTH-1:0]   rdata;
  axi4::resp_t             rresp;

  modport master (
    input  aclk, aresetn,
    output awvalid, awaddr, awprot, input awready,
    output wvalid, wdata, wstrb,    input wready,
    input  bvalid, bresp,           output bready,
    output arvalid, araddr, arprot, input arready,
    input  rvalid, rdata, rresp,    output rready
  );

  modport slave (
    input  aclk, aresetn,
    input  awvalid, awaddr, awprot, output awready,
    input  wvalid, wdata, wstrb,    output wready,
    output bvalid, bresp,           input bready,
    input  arvalid, araddr, arprot, output arready,
    output rvalid, rdata, rresp,    input rready
  );

endinterface

// File: rtl/axi_lsu.sv
// Single-outstanding AXI4-Lite master turning one core load/store into one AXI transaction.
// Optional: define AXI_LSU_ALIGN_CHECK_EN to reject non-word-aligned requests without bus traffic.
module axi_lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  axi.master                      data
);

  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WRITE, WRESP, RESP} state_t;

  state_t   state;
  lsu_req_t req, req_q;
  lsu_rsp_t rsp_q;
  logic     awvalid_q, wvalid_q, arvalid_q, bready_q, rready_q;
  logic     aw_done, w_done;
  logic     aw_hs, w_hs, misaligned;

  assign req = '{write: req_write, addr: req_addr, wdata: req_wdata, wstrb: req_wstrb};

`ifdef AXI_LSU_ALIGN_CHECK_EN
  assign misaligned = !word_aligned(req.addr);
`else
  assign misaligned = 1'b0;
`endif

  assign aw_hs = awvalid_q && data.awready;
  assign w_hs  = wvalid_q && data.wready;

  assign data.awvalid = awvalid_q;
  assign data.awaddr  = req_q.addr;
  assign data.awprot  = 3'b000;
  assign data.wvalid  = wvalid_q;
  assign data.wdata   = req_q.wdata;
  assign data.wstrb   = req_q.wstrb;
  assign data.bready  = bready_q;
  assign data.arvalid = arvalid_q;
  assign data.araddr  = req_q.addr;
  assign data.arprot  = 3'b000;
  assign data.rready  = rready_q;

  assign rsp_rdata = rsp_q.rdata;
  assign rsp_err   = rsp_q.err;

  // NOTE: every register here is assigned with <= so all branches see pre-edge values
  // regardless of statement order; a later <= to the same register simply wins.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      req_q     <= '0;
      rsp_q     <= '0;
      rsp_valid <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      rready_q  <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            req_q     <= req;
            if (misaligned) begin
              rsp_q     <= '{rdata: '0, err: 1'b1};
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else if (req.write) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              aw_done   <= 1'b0;
              w_done    <= 1'b0;
              state     <= WRITE;
            end else begin
              arvalid_q <= 1'b1;
              state     <= RADDR;
            end
          end
        end
        RADDR: if (data.arready) begin
          arvalid_q <= 1'b0;
          rready_q  <= 1'b1;
          state     <= RDATA;
        end
        RDATA: if (data.rvalid) begin
          rready_q  <= 1'b0;
          rsp_q     <= '{rdata: (data.rresp == axi4::OKAY) ? data.rdata : '0,
                         err:   data.rresp != axi4::OKAY};
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        WRITE: begin
          // AW and W complete independently; leave once both have handshaken.
          if (aw_hs) begin
            awvalid_q <= 1'b0;
            aw_done   <= 1'b1;
          end
          if (w_hs) begin
            wvalid_q <= 1'b0;
            w_done   <= 1'b1;
          end
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            bready_q <= 1'b1;
            state    <= WRESP;
          end
        end
        WRESP: if (data.bvalid) begin
          bready_q  <= 1'b0;
          rsp_q     <= '{rdata: '0, err: data.bresp != axi4::OKAY};
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lsu.sv
// Bench for axi_lsu: AXI4-Lite RAM slave with programmable delays/errors and a word-array reference model.
module tb_axi_lsu;
  import axi4::*;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  always #5 aclk = ~aclk;

  axi #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus (.aclk(aclk), .aresetn(aresetn));

  axi_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .data(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Slave knobs, changed only between transactions
  int   aw_dly = 0, w_dly = 0, ar_dly = 0, r_dly = 0, b_dly = 0;
  logic r_err = 1'b0, b_err = 1'b0;

  logic [31:0] mem [1024];
  logic [31:0] ref_mem [1024];
  logic        mem_init = 1'b0;
  logic        aw_got, w_got, ar_got;
  logic [31:0] aw_addr, w_data, ar_addr;
  logic [3:0]  w_strb;
  int          aw_cnt, w_cnt, ar_cnt, r_cnt, b_cnt;

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      if (!mem_init) begin
        for (int i = 0; i < 1024; i++) mem[i] <= '0;
        mem_init <= 1'b1;
      end
      bus.awready <= 1'b0; bus.wready <= 1'b0; bus.arready <= 1'b0;
      bus.bvalid  <= 1'b0; bus.rvalid <= 1'b0;
      bus.bresp   <= OKAY; bus.rresp  <= OKAY; bus.rdata <= '0;
      aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
      aw_addr <= '0; w_data <= '0; w_strb <= '0; ar_addr <= '0;
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; r_cnt <= 0; b_cnt <= 0;
    end else begin
      if (bus.awvalid && bus.awready) begin
        bus.awready <= 1'b0; aw_got <= 1'b1; aw_addr <= bus.awaddr;
      end else if (bus.awvalid && !aw_got && !bus.awready) begin
        if (aw_cnt >= aw_dly) begin bus.awready <= 1'b1; aw_cnt <= 0; end
        else aw_cnt <= aw_cnt + 1;
      end
      if (bus.wvalid && bus.wready) begin
        bus.wready <= 1'b0; w_got <= 1'b1; w_data <= bus.wdata; w_strb <= bus.wstrb;
      end else if (bus.wvalid && !w_got && !bus.wready) begin
        if (w_cnt >= w_dly) begin bus.wready <= 1'b1; w_cnt <= 0; end
        else w_cnt <= w_cnt + 1;
      end
      if (aw_got && w_got && !bus.bvalid) begin
        if (b_cnt >= b_dly) begin
          if (!b_err)
            for (int b = 0; b < 4; b++)
              if (w_strb[b]) mem[aw_addr[11:2]][8*b +: 8] <= w_data[8*b +: 8];
          bus.bvalid <= 1'b1; bus.bresp <= b_err ? SLVERR : OKAY; b_cnt <= 0;
        end else b_cnt <= b_cnt + 1;
      end
      if (bus.bvalid && bus.bready) begin
        bus.bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
      end
      if (bus.arvalid && bus.arready) begin
        bus.arready <= 1'b0; ar_got <= 1'b1; ar_addr <= bus.araddr; r_cnt <= 0;
        if (r_dly == 0) begin
          bus.rvalid <= 1'b1; bus.rdata <= mem[bus.araddr[11:2]];
          bus.rresp  <= r_err ? SLVERR : OKAY;
        end
      end else if (bus.arvalid && !ar_got && !bus.arready) begin
        if (ar_cnt >= ar_dly) begin bus.arready <= 1'b1; ar_cnt <= 0; end
        else ar_cnt <= ar_cnt + 1;
      end
      if (ar_got && !bus.rvalid && r_dly > 0) begin
        if (r_cnt >= r_dly - 1) begin
          bus.rvalid <= 1'b1; bus.rdata <= mem[ar_addr[11:2]];
          bus.rresp  <= r_err ? SLVERR : OKAY;
        end else r_cnt <= r_cnt + 1;
      end
      if (bus.rvalid && bus.rready) begin
        bus.rvalid <= 1'b0; ar_got <= 1'b0;
      end
    end
  end

  // Bus monitor: handshake tallies and protocol rule violations
  int cyc = 0;
  int aw_hs_n = 0, w_hs_n = 0, b_hs_n = 0, ar_hs_n = 0, r_hs_n = 0, ar_seen_n = 0, rsp_rise_n = 0, viol_n = 0;
  logic        p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_rspv;
  logic [31:0] p_awaddr, p_wdata, p_araddr;
  logic [3:0]  p_wstrb;

  always @(posedge aclk) cyc <= cyc + 1;

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      {p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_rspv} <= '0;
      p_awaddr <= '0; p_wdata <= '0; p_araddr <= '0; p_wstrb <= '0;
    end else begin
      if (bus.awvalid && bus.awready) aw_hs_n <= aw_hs_n + 1;
      if (bus.wvalid && bus.wready)   w_hs_n  <= w_hs_n + 1;
      if (bus.bvalid && bus.bready)   b_hs_n  <= b_hs_n + 1;
      if (bus.arvalid && bus.arready) ar_hs_n <= ar_hs_n + 1;
      if (bus.rvalid && bus.rready)   r_hs_n  <= r_hs_n + 1;
      if (bus.arvalid)                ar_seen_n <= ar_seen_n + 1;
      if (rsp_valid && !p_rspv)       rsp_rise_n <= rsp_rise_n + 1;
      if ((p_awv && !p_awr && (!bus.awvalid || bus.awaddr != p_awaddr)) ||
          (p_wv && !p_wr && (!bus.wvalid || bus.wdata != p_wdata || bus.wstrb != p_wstrb)) ||
          (p_arv && !p_arr && (!bus.arvalid || bus.araddr != p_araddr)) ||
          (bus.awvalid && aw_got) || (bus.wvalid && w_got) || (bus.arvalid && ar_got) ||
          ((bus.awvalid || bus.arvalid) && (bus.awprot != 3'b000 || bus.arprot != 3'b000)))
        viol_n <= viol_n + 1;
      p_awv <= bus.awvalid; p_awr <= bus.awready; p_awaddr <= bus.awaddr;
      p_wv  <= bus.wvalid;  p_wr  <= bus.wready;  p_wdata  <= bus.wdata; p_wstrb <= bus.wstrb;
      p_arv <= bus.arvalid; p_arr <= bus.arready; p_araddr <= bus.araddr;
      p_rspv <= rsp_valid;
    end
  end

  // One request end to end; called on a negedge, returns on a negedge.
  task automatic run_req(input string tag, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] st, input int hold, input int exp_lat);
    logic [31:0] exp_data, m;
    logic        exp_err, mis;
    int          n, acc, aw0, w0, b0, ar0, r0, as0, rs0, v0;
    logic [3:0]  exp_aw, exp_ar;
`ifdef AXI_LSU_ALIGN_CHECK_EN
    mis = addr[1:0] != 2'b00;
`else
    mis = 1'b0;
`endif
    if (mis) begin
      exp_err = 1'b1; exp_data = '0;
    end else if (wr) begin
      exp_err = b_err; exp_data = '0;
      if (!b_err)
        for (int b = 0; b < 4; b++) begin
          m = st[b] ? (32'hFF << (8 * b)) : 32'h0;
          ref_mem[addr[11:2]] = (ref_mem[addr[11:2]] & ~m) | (wd & m);
        end
    end else begin
      exp_err = r_err; exp_data = r_err ? 32'h0 : ref_mem[addr[11:2]];
    end
    exp_aw = (!mis && wr) ? 4'd1 : 4'd0;
    exp_ar = (!mis && !wr) ? 4'd1 : 4'd0;
    aw0 = aw_hs_n; w0 = w_hs_n; b0 = b_hs_n; ar0 = ar_hs_n; r0 = r_hs_n;
    as0 = ar_seen_n; rs0 = rsp_rise_n; v0 = viol_n;

    n = 0;
    while (!req_ready && n < 200) begin @(negedge aclk); n++; end
    if (!req_ready) begin check({tag, " req_ready timeout"}, {31'h0, req_ready}, 32'h1); return; end
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd; req_wstrb = st;
    acc = cyc;
    @(negedge aclk);
    req_valid = 1'b0;
    check({tag, " req_ready after accept"}, {31'h0, req_ready}, 32'h0);
    n = 0;
    while (!rsp_valid && n < 200) begin @(negedge aclk); n++; end
    if (!rsp_valid) begin check({tag, " rsp timeout"}, {31'h0, rsp_valid}, 32'h1); return; end
    if (exp_lat > 0) check({tag, " latency"}, 32'(cyc - acc), 32'(exp_lat));
    check({tag, " rdata"}, rsp_rdata, exp_data);
    check({tag, " err"}, {31'h0, rsp_err}, {31'h0, exp_err});
    for (int i = 0; i < hold; i++) begin
      @(negedge aclk);
      check({tag, " hold"}, {rsp_valid, req_ready, rsp_err, rsp_rdata[28:0]},
            {1'b1, 1'b0, exp_err, exp_data[28:0]});
    end
    rsp_ready = 1'b1;
    @(negedge aclk);
    rsp_ready = 1'b0;
    check({tag, " rsp_valid drop / req_ready back"}, {30'h0, rsp_valid, req_ready}, 32'h1);
    check({tag, " bus tally"},
          {4'(aw_hs_n - aw0), 4'(w_hs_n - w0), 4'(b_hs_n - b0), 4'(ar_hs_n - ar0),
           4'(r_hs_n - r0), 4'(rsp_rise_n - rs0), 8'(viol_n - v0)},
          {exp_aw, exp_aw, exp_aw, exp_ar, exp_ar, 4'd1, 8'd0});
    if (mis) check({tag, " no arvalid"}, 32'(ar_seen_n - as0), 32'h0);
  endtask

  initial begin
    int n;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
    #2;
    check("reset flags", {24'h0, req_ready, bus.awvalid, bus.wvalid, bus.arvalid,
                          bus.bready, bus.rready, rsp_valid, rsp_err}, 32'h0);
    check("reset rdata", rsp_rdata, 32'h0);
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);

    run_req("st full", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, -1);
    run_req("ld full", 1'b0, 32'h10, 32'h0, 4'h0, 0, 4);
    run_req("st byte", 1'b1, 32'h10, 32'h0000AA00, 4'h2, 0, -1);
    run_req("ld byte", 1'b0, 32'h10, 32'h0, 4'h0, 0, 4);

    w_dly = 3;
    run_req("st slow w", 1'b1, 32'h20, 32'h12345678, 4'hF, 0, -1);
    w_dly = 0;

    r_err = 1'b1;
    run_req("ld slverr", 1'b0, 32'h10, 32'h0, 4'h0, 5, 4);
    r_err = 1'b0;

    // Reset while waiting for read data
    r_dly = 10;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge aclk); n++; end
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10;
    @(negedge aclk);
    req_valid = 1'b0;
    n = 0;
    while (!bus.rready && n < 50) begin @(negedge aclk); n++; end
    check("rdata state reached", {31'h0, bus.rready}, 32'h1);
    aresetn = 1'b0;
    #1;
    check("mid reset flags", {24'h0, req_ready, bus.awvalid, bus.wvalid, bus.arvalid,
                              bus.bready, bus.rready, rsp_valid, rsp_err}, 32'h0);
    r_dly = 0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    run_req("ld after reset", 1'b0, 32'h10, 32'h0, 4'h0, 0, 4);

`ifdef AXI_LSU_ALIGN_CHECK_EN
    run_req("ld misaligned", 1'b0, 32'h12, 32'h0, 4'h0, 0, 1);
`else
    run_req("ld misaligned", 1'b0, 32'h12, 32'h0, 4'h0, 0, 4);
`endif

    for (int t = 0; t < 40; t++) begin
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); ar_dly = $urandom_range(0, 3);
      r_dly  = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
      r_err  = ($urandom_range(0, 7) == 0); b_err = ($urandom_range(0, 7) == 0);
      run_req("rand", 1'($urandom_range(0, 1)), {20'h0, 6'($urandom_range(0, 63)), 2'b00}, $urandom(),
              4'($urandom_range(0, 15)), $urandom_range(0, 2), -1);
    end
    r_err = 1'b0; b_err = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
